// File: rtl/ahb_2m1s_arbiter_if.sv
// Bus bundle for the two-master / one-slave AHB-Lite arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding fabric.
interface ahb_2m1s_arbiter_if #(
  parameter int unsigned SZ = 64
);
  logic [31:0]   HADDR_M1,  HADDR_M2;
  logic [1:0]    HTRANS_M1, HTRANS_M2;
  logic          HWRITE_M1, HWRITE_M2;
  logic [2:0]    HSIZE_M1,  HSIZE_M2;
  logic [SZ-1:0] HWDATA_M1, HWDATA_M2;
  logic          HREADY_M1, HREADY_M2;
  logic          HRESP_M1,  HRESP_M2;
  logic [SZ-1:0] HRDATA_M1, HRDATA_M2;

  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [SZ-1:0] HWDATA;
  logic          HREADY;
  logic          HRESP;
  logic [SZ-1:0] HRDATA;

  modport slave (
    input  HADDR_M1, HADDR_M2, HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2,
           HSIZE_M1, HSIZE_M2, HWDATA_M1, HWDATA_M2, HREADY, HRESP, HRDATA,
    output HREADY_M1, HREADY_M2, HRESP_M1, HRESP_M2, HRDATA_M1, HRDATA_M2,
           HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport master (
    output HADDR_M1, HADDR_M2, HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2,
           HSIZE_M1, HSIZE_M2, HWDATA_M1, HWDATA_M2, HREADY, HRESP, HRDATA,
    input  HREADY_M1, HREADY_M2, HRESP_M1, HRESP_M2, HRDATA_M1, HRDATA_M2,
           HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/ahb_2m1s_arbiter.sv
// AHB-Lite arbiter sharing one slave between IFU (M1) and LSU (M2); a losing master's
// address phase is buffered so that master never sees a false data-phase extension.
module ahb_2m1s_arbiter #(
  parameter int unsigned SZ       = 64,
  parameter bit          ARB_MODE = 1'b1
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_2m1s_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_M1, OWN_M2} own_e;
  typedef enum logic {RR_M1, RR_M2} rr_e;

  own_e        r_dph_own;
  rr_e         r_rr_last;
  logic        r_pend1, r_pend2;
  logic [31:0] r_paddr1, r_paddr2;
  logic        r_pwrite1, r_pwrite2;
  logic [2:0]  r_psize1, r_psize2;
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [2:0]  r_hsize;

  logic        w_rdy1, w_rdy2, w_live1, w_live2, w_req1, w_req2, w_gnt1, w_gnt2;
  logic [31:0] w_haddr;
  logic [1:0]  w_htrans;
  logic        w_hwrite;
  logic [2:0]  w_hsize;
  logic        w_unused;

  assign w_unused = &{1'b0, bus.HTRANS_M1[0], bus.HTRANS_M2[0]};

  always_comb begin
    w_rdy1  = r_pend1 ? 1'b0 : (r_dph_own == OWN_M1) ? bus.HREADY : 1'b1;
    w_rdy2  = r_pend2 ? 1'b0 : (r_dph_own == OWN_M2) ? bus.HREADY : 1'b1;
    w_live1 = w_rdy1 & bus.HTRANS_M1[1];
    w_live2 = w_rdy2 & bus.HTRANS_M2[1];
    w_req1  = r_pend1 | w_live1;
    w_req2  = r_pend2 | w_live2;
    w_gnt1  = 1'b0;
    w_gnt2  = 1'b0;
    if (bus.HREADY && !HRESET) begin
      if (w_req1 && w_req2) begin
        if (!ARB_MODE || r_rr_last == RR_M2) w_gnt1 = 1'b1;
        else                                 w_gnt2 = 1'b1;
      end else begin
        w_gnt1 = w_req1;
        w_gnt2 = w_req2;
      end
    end
  end

  // While the slave stalls, the bus shows the address phase registered at the last ready cycle.
  always_comb begin
    w_haddr  = '0;
    w_htrans = '0;
    w_hwrite = 1'b0;
    w_hsize  = '0;
    if (HRESET) begin
      w_htrans = '0;
    end else if (!bus.HREADY) begin
      w_haddr  = r_haddr;
      w_htrans = r_htrans;
      w_hwrite = r_hwrite;
      w_hsize  = r_hsize;
    end else if (w_gnt1) begin
      w_htrans = 2'b10;
      w_haddr  = r_pend1 ? r_paddr1  : bus.HADDR_M1;
      w_hwrite = r_pend1 ? r_pwrite1 : bus.HWRITE_M1;
      w_hsize  = r_pend1 ? r_psize1  : bus.HSIZE_M1;
    end else if (w_gnt2) begin
      w_htrans = 2'b10;
      w_haddr  = r_pend2 ? r_paddr2  : bus.HADDR_M2;
      w_hwrite = r_pend2 ? r_pwrite2 : bus.HWRITE_M2;
      w_hsize  = r_pend2 ? r_psize2  : bus.HSIZE_M2;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dph_own <= OWN_NONE;
      r_rr_last <= RR_M2;
      r_pend1   <= 1'b0;
      r_pend2   <= 1'b0;
      r_paddr1  <= '0;
      r_paddr2  <= '0;
      r_pwrite1 <= 1'b0;
      r_pwrite2 <= 1'b0;
      r_psize1  <= '0;
      r_psize2  <= '0;
      r_haddr   <= '0;
      r_htrans  <= '0;
      r_hwrite  <= 1'b0;
      r_hsize   <= '0;
    end else begin
      if (w_live1 && !w_gnt1) begin
        r_pend1   <= 1'b1;
        r_paddr1  <= bus.HADDR_M1;
        r_pwrite1 <= bus.HWRITE_M1;
        r_psize1  <= bus.HSIZE_M1;
      end else if (r_pend1 && w_gnt1) begin
        r_pend1 <= 1'b0;
      end
      if (w_live2 && !w_gnt2) begin
        r_pend2   <= 1'b1;
        r_paddr2  <= bus.HADDR_M2;
        r_pwrite2 <= bus.HWRITE_M2;
        r_psize2  <= bus.HSIZE_M2;
      end else if (r_pend2 && w_gnt2) begin
        r_pend2 <= 1'b0;
      end
      if (bus.HREADY) begin
        r_dph_own <= w_gnt1 ? OWN_M1 : w_gnt2 ? OWN_M2 : OWN_NONE;
        r_haddr   <= w_haddr;
        r_htrans  <= w_htrans;
        r_hwrite  <= w_hwrite;
        r_hsize   <= w_hsize;
        if (w_gnt1)      r_rr_last <= RR_M1;
        else if (w_gnt2) r_rr_last <= RR_M2;
      end
    end
  end

  assign bus.HREADY_M1 = w_rdy1;
  assign bus.HREADY_M2 = w_rdy2;
  assign bus.HRESP_M1  = (r_dph_own == OWN_M1) & bus.HRESP;
  assign bus.HRESP_M2  = (r_dph_own == OWN_M2) & bus.HRESP;
  assign bus.HRDATA_M1 = bus.HRDATA;
  assign bus.HRDATA_M2 = bus.HRDATA;
  assign bus.HADDR     = w_haddr;
  assign bus.HTRANS    = w_htrans;
  assign bus.HWRITE    = w_hwrite;
  assign bus.HSIZE     = w_hsize;
  assign bus.HWDATA    = (r_dph_own == OWN_M1) ? bus.HWDATA_M1 :
                         (r_dph_own == OWN_M2) ? bus.HWDATA_M2 : '0;
endmodule

// File: tb/tb_ahb_2m1s_arbiter.sv
// Bench for ahb_2m1s_arbiter: one instance per arbitration mode, driven by identical stimulus.
module tb_ahb_2m1s_arbiter;
  localparam int unsigned SZ = 64;
  localparam logic [63:0] WD1 = 64'h11;
  localparam logic [63:0] WD2 = 64'hDEADBEEF;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic [1:0]  s_t1, s_t2;
  logic [31:0] s_a1, s_a2;
  logic        s_w1, s_w2;
  logic [2:0]  s_z1, s_z2;
  logic [63:0] s_wd1, s_wd2, s_rd;
  logic        s_hr, s_resp;

  typedef struct packed {
    logic        rdy1, rdy2, resp1, resp2;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] wdata, rd1, rd2;
  } obs_t;

  obs_t obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_2m1s_arbiter_if #(.SZ(SZ)) bus ();
    assign bus.HADDR_M1  = s_a1;
    assign bus.HADDR_M2  = s_a2;
    assign bus.HTRANS_M1 = s_t1;
    assign bus.HTRANS_M2 = s_t2;
    assign bus.HWRITE_M1 = s_w1;
    assign bus.HWRITE_M2 = s_w2;
    assign bus.HSIZE_M1  = s_z1;
    assign bus.HSIZE_M2  = s_z2;
    assign bus.HWDATA_M1 = s_wd1;
    assign bus.HWDATA_M2 = s_wd2;
    assign bus.HREADY    = s_hr;
    assign bus.HRESP     = s_resp;
    assign bus.HRDATA    = s_rd;
    ahb_2m1s_arbiter #(.SZ(SZ), .ARB_MODE(g != 0)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );
    assign obs[g] = {bus.HREADY_M1, bus.HREADY_M2, bus.HRESP_M1, bus.HRESP_M2, bus.HTRANS,
                     bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA, bus.HRDATA_M1, bus.HRDATA_M2};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-mode pending slot per master, data-phase owner and last winner as integers.
  typedef struct packed { logic [31:0] addr; logic wr; logic [2:0] sz; } xfer_t;
  typedef struct packed { logic [1:0] trans; logic [31:0] addr; logic wr; logic [2:0] sz; } bus_t;
  int    pc   [2][3];
  xfer_t pbuf [2][3];
  int    own  [2];
  int    last [2];
  bus_t  held [2];

  task automatic model_reset(input int m);
    pc[m][1] = 0; pc[m][2] = 0; own[m] = 0; last[m] = 2; held[m] = '0;
  endtask

  task automatic model_cycle(input int m, output obs_t e);
    xfer_t src [3];
    logic [1:0] tr [3];
    logic [63:0] wd [3];
    bit rdy [3];
    bit live [3];
    bit want [3];
    int win;
    bus_t b;
    src[0] = '0; src[1] = {s_a1, s_w1, s_z1}; src[2] = {s_a2, s_w2, s_z2};
    tr[0] = '0; tr[1] = s_t1; tr[2] = s_t2;
    wd[0] = '0; wd[1] = s_wd1; wd[2] = s_wd2;
    rdy[0] = 1'b0; live[0] = 1'b0; want[0] = 1'b0;
    if (HRESET) model_reset(m);
    for (int x = 1; x <= 2; x++) begin
      rdy[x]  = (pc[m][x] != 0) ? 1'b0 : (own[m] == x) ? s_hr : 1'b1;
      live[x] = rdy[x] && tr[x][1] && !HRESET;
      want[x] = (pc[m][x] != 0) || live[x];
    end
    win = 0;
    if (s_hr && !HRESET) begin
      if (want[1] && want[2]) win = (m == 0) ? 1 : 3 - last[m];
      else if (want[1])       win = 1;
      else if (want[2])       win = 2;
    end
    if (HRESET)         b = '0;
    else if (!s_hr)     b = held[m];
    else if (win == 0)  b = '0;
    else                b = {2'b10, (pc[m][win] != 0) ? pbuf[m][win] : src[win]};
    e = '0;
    e.rdy1  = rdy[1];
    e.rdy2  = rdy[2];
    e.resp1 = (own[m] == 1) && s_resp;
    e.resp2 = (own[m] == 2) && s_resp;
    e.trans = b.trans;
    e.addr  = b.addr;
    e.wr    = b.wr;
    e.sz    = b.sz;
    e.wdata = wd[own[m]];
    e.rd1   = s_rd;
    e.rd2   = s_rd;
    if (!HRESET) begin
      for (int x = 1; x <= 2; x++) begin
        if (live[x] && win != x) begin
          pbuf[m][x] = src[x];
          pc[m][x]   = 1;
        end else if (pc[m][x] != 0 && win == x) begin
          pc[m][x] = 0;
        end
      end
      if (s_hr) begin
        own[m]  = win;
        held[m] = b;
        if (win != 0) last[m] = win;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  t1, t2;
    logic [31:0] a1, a2;
    logic        hr, resp;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
    logic [63:0] e_wd;
    logic [3:0]  e_rr;   // {HREADY_M1, HREADY_M2, HRESP_M1, HRESP_M2}
  } vec_t;

  vec_t tbl [14];

  task automatic set_idle();
    s_t1 = 2'b00; s_t2 = 2'b00; s_a1 = '0; s_a2 = '0;
    s_w1 = 1'b0; s_w2 = 1'b1; s_z1 = 3'd2; s_z2 = 3'd3;
    s_wd1 = WD1; s_wd2 = WD2; s_rd = 64'hCAFE_F00D_1234_5678;
    s_hr = 1'b1; s_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    set_idle();
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    obs_t e;
    int   exp_m;
    tbl[0]  = '{2'd0, 2'd0, 32'h0,    32'h0,    1'b1, 1'b0, 32'h0,    2'd0, 64'h0, 4'b1100};
    tbl[1]  = '{2'd2, 2'd2, 32'h100,  32'h200,  1'b1, 1'b0, 32'h100,  2'd2, 64'h0, 4'b1100};
    tbl[2]  = '{2'd0, 2'd2, 32'h0,    32'h200,  1'b1, 1'b0, 32'h200,  2'd2, WD1,   4'b1000};
    tbl[3]  = '{2'd0, 2'd0, 32'h0,    32'h0,    1'b1, 1'b0, 32'h0,    2'd0, WD2,   4'b1100};
    tbl[4]  = '{2'd2, 2'd0, 32'h1000, 32'h0,    1'b1, 1'b0, 32'h1000, 2'd2, 64'h0, 4'b1100};
    tbl[5]  = '{2'd0, 2'd0, 32'h0,    32'h0,    1'b1, 1'b0, 32'h0,    2'd0, WD1,   4'b1100};
    tbl[6]  = '{2'd0, 2'd2, 32'h0,    32'h2000, 1'b1, 1'b0, 32'h2000, 2'd2, 64'h0, 4'b1100};
    tbl[7]  = '{2'd2, 2'd0, 32'h3000, 32'h0,    1'b0, 1'b0, 32'h2000, 2'd2, WD2,   4'b1000};
    tbl[8]  = '{2'd2, 2'd0, 32'h3000, 32'h0,    1'b0, 1'b0, 32'h2000, 2'd2, WD2,   4'b0000};
    tbl[9]  = '{2'd2, 2'd0, 32'h3000, 32'h0,    1'b0, 1'b0, 32'h2000, 2'd2, WD2,   4'b0000};
    tbl[10] = '{2'd2, 2'd0, 32'h3000, 32'h0,    1'b1, 1'b0, 32'h3000, 2'd2, WD2,   4'b0100};
    tbl[11] = '{2'd0, 2'd2, 32'h0,    32'h4000, 1'b1, 1'b0, 32'h4000, 2'd2, WD1,   4'b1100};
    tbl[12] = '{2'd0, 2'd0, 32'h0,    32'h0,    1'b1, 1'b1, 32'h0,    2'd0, WD2,   4'b1101};
    tbl[13] = '{2'd0, 2'd0, 32'h0,    32'h0,    1'b1, 1'b1, 32'h0,    2'd0, 64'h0, 4'b1100};

    set_idle();
    HRESET = 1'b1;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset m%0d rdy/resp", m), {obs[m].rdy1, obs[m].rdy2, obs[m].resp1, obs[m].resp2}, 4'b1100);
      chk($sformatf("reset m%0d bus", m), {obs[m].trans, obs[m].addr, obs[m].wr, obs[m].sz, obs[m].wdata}, '0);
    end
    @(negedge HCLK);
    HRESET = 1'b0;

    // Directed cycle table: split/replay, single read, stalled write with captured read, error response.
    for (int i = 0; i < 14; i++) begin
      @(negedge HCLK);
      s_t1 = tbl[i].t1; s_t2 = tbl[i].t2; s_a1 = tbl[i].a1; s_a2 = tbl[i].a2;
      s_hr = tbl[i].hr; s_resp = tbl[i].resp;
      #2;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d m%0d rdy/resp", i, m),
            {obs[m].rdy1, obs[m].rdy2, obs[m].resp1, obs[m].resp2}, tbl[i].e_rr);
        chk($sformatf("vec%0d m%0d htrans", i, m), obs[m].trans, tbl[i].e_trans);
        chk($sformatf("vec%0d m%0d haddr", i, m), obs[m].addr, tbl[i].e_addr);
        chk($sformatf("vec%0d m%0d hwdata", i, m), obs[m].wdata, tbl[i].e_wd);
      end
    end

    // Both masters streaming: mode 1 alternates, mode 0 lets M2 in only once M1 goes idle.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge HCLK);
      s_t1 = (c < 8) ? 2'b10 : 2'b00;
      s_t2 = 2'b10;
      s_a1 = 32'h1000 + 32'(c * 4);
      s_a2 = 32'h2000 + 32'(c * 4);
      #2;
      for (int m = 0; m < 2; m++) begin
        exp_m = (m == 1) ? ((c % 2 == 0) ? 1 : 2) : ((c < 8) ? 1 : 2);
        chk($sformatf("stream c%0d m%0d owner", c, m), {obs[m].trans, obs[m].addr[15:12]},
            {2'b10, 4'(exp_m)});
      end
    end

    // Reset while M2 is buffered and M1 owns the data phase.
    do_reset();
    @(negedge HCLK);
    s_t1 = 2'b10; s_t2 = 2'b10; s_a1 = 32'h500; s_a2 = 32'h600;
    @(negedge HCLK);
    s_t1 = 2'b00;
    #2;
    for (int m = 0; m < 2; m++)
      chk($sformatf("prereset m%0d state", m), {obs[m].rdy1, obs[m].rdy2, obs[m].wdata}, {2'b10, WD1});
    s_t1 = 2'b10;
    HRESET = 1'b1;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("midreset m%0d rdy/resp", m), {obs[m].rdy1, obs[m].rdy2, obs[m].resp1, obs[m].resp2}, 4'b1100);
      chk($sformatf("midreset m%0d bus", m), {obs[m].trans, obs[m].addr, obs[m].wr, obs[m].sz, obs[m].wdata}, '0);
    end

    // Random traffic against the reference model, with occasional resets.
    model_reset(0);
    model_reset(1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge HCLK);
      HRESET = (c == 0) || ($urandom_range(0, 199) == 0);
      s_t1 = 2'($urandom_range(0, 3));
      s_t2 = 2'($urandom_range(0, 3));
      s_a1 = $urandom; s_a2 = $urandom;
      s_w1 = 1'($urandom_range(0, 1)); s_w2 = 1'($urandom_range(0, 1));
      s_z1 = 3'($urandom_range(0, 7)); s_z2 = 3'($urandom_range(0, 7));
      s_wd1 = {$urandom, $urandom}; s_wd2 = {$urandom, $urandom}; s_rd = {$urandom, $urandom};
      s_hr = ($urandom_range(0, 9) < 7);
      s_resp = ($urandom_range(0, 9) == 0);
      #2;
      for (int m = 0; m < 2; m++) begin
        model_cycle(m, e);
        chk($sformatf("rnd c%0d m%0d", c, m), obs[m], e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
